// File: rtl/frame_sequencer.sv
// frame_sequencer: APU frame-sequencer timebase.
// Steps 0..7 advance once per sequencer period. The registered strobes are
// length (steps 0,2,4,6), sweep (steps 2,6) and envelope (step 7), together
// with a 50% duty fs_clk square wave.
// Optional feature macro: FS_EXT_DIV_EN. When it is defined, the falling edge
// of the external div_bit replaces the internal CLK_DIV counter.
module frame_sequencer #(
  parameter int CLK_DIV = 8192
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_en,
`ifdef FS_EXT_DIV_EN
  input  logic       div_bit,
`endif
  output logic [2:0] step,
  output logic       fs_clk,
  output logic       length_tick,
  output logic       sweep_tick,
  output logic       env_tick
);

  // Strobe decode of a step value, packed as {length, sweep, envelope}
  function automatic logic [2:0] decode_strobes(input logic [2:0] s);
    logic [2:0] d;
    d[2] = (s[0] == 1'b0);
    d[1] = (s == 3'd2) || (s == 3'd6);
    d[0] = (s == 3'd7);
    return d;
  endfunction

  logic [2:0] step_r;
  logic       fs_clk_r;
  logic [2:0] strobe_r;      // {length, sweep, envelope}
  logic       tick_s;
  logic       fs_next_s;
  logic [2:0] step_next_s;
  logic [2:0] strobe_next_s;

`ifdef FS_EXT_DIV_EN
  logic div_last_r;

  // Track div_bit every cycle, idle included, so enabling never fakes an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      div_last_r <= 1'b0;
    end else begin
      div_last_r <= div_bit;
    end
  end

  // Tick on a sampled falling edge of div_bit; fs_clk follows the delayed bit
  always_comb begin
    tick_s    = apu_en && div_last_r && !div_bit;
    fs_next_s = div_bit;
  end
`else
  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Period counter: tick on the last count, fs_clk high for the first half
  always_comb begin
    tick_s     = 1'b0;
    cnt_next_s = {CNT_W{1'b0}};
    if (apu_en && (cnt_r == CNT_MAX)) begin
      tick_s     = 1'b1;
      cnt_next_s = {CNT_W{1'b0}};
    end else begin
      tick_s     = 1'b0;
      cnt_next_s = cnt_r + CNT_W'(1);
    end
    fs_next_s = (cnt_next_s < CNT_HALF);
  end

  // Counter register; idle or reset discards any partial period
  always_ff @(posedge clk) begin
    if (reset || !apu_en) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end
`endif

  // Next step and the strobes decoded from that new step
  always_comb begin
    step_next_s   = step_r;
    strobe_next_s = 3'b000;
    if (tick_s) begin
      step_next_s   = step_r + 3'd1;
      strobe_next_s = decode_strobes(step_next_s);
    end else begin
      step_next_s   = step_r;
      strobe_next_s = 3'b000;
    end
  end

  // Output registers; step parks at 7 so the first step entered is 0
  always_ff @(posedge clk) begin
    if (reset || !apu_en) begin
      step_r   <= 3'd7;
      fs_clk_r <= 1'b0;
      strobe_r <= 3'b000;
    end else begin
      step_r   <= step_next_s;
      fs_clk_r <= fs_next_s;
      strobe_r <= strobe_next_s;
    end
  end

  assign step        = step_r;
  assign fs_clk      = fs_clk_r;
  assign length_tick = strobe_r[2];
  assign sweep_tick  = strobe_r[1];
  assign env_tick    = strobe_r[0];

endmodule
